// File: rtl/ram_pkg.sv
// ram_pkg: shared constants, FSM state type and index-width helper for the
// line-granular backing memory (ram_line_model and ram_line_array).
//   LINE_W           : width of one cache line in bits
//   ADDR_W           : byte-address width of the request port
//   DEFAULT_OFFSET_W : byte-offset bits inside a 64-byte line
//   state_t          : IDLE / BUSY / RESPOND transaction states
//   idx_width()      : line-index width derived from the array depth
package ram_pkg;

  localparam int LINE_W           = 512;
  localparam int ADDR_W           = 32;
  localparam int DEFAULT_OFFSET_W = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_line_array.sv
// ram_line_array: single-port synchronous DEPTH x LINE_W line store.
// Storage is never reset; only the registered read data is cleared by rst.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset (clears read_data, blocks writes)
//   en         : port enable for this edge
//   we         : 1 = write write_data to line index, 0 = read line into read_data
//   index      : line index
//   write_data : line to store
//   read_data  : registered read line; holds its value when not reading
module ram_line_array
  import ram_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  index,
  input  logic [LINE_W-1:0] write_data,
  output logic [LINE_W-1:0] read_data
);

  logic [LINE_W-1:0] mem [DEPTH];

  // Contents survive reset; a write landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (en && we && !rst) begin
      mem[index] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= '0;
    end else if (en && !we) begin
      read_data <= mem[index];
    end
  end

endmodule

// File: rtl/ram_line_model.sv
// ram_line_model: fixed-latency line memory answering the cache controller's
// RAM request handshake (fetch and write-back of 512-bit lines).
// Optional statistics counters are built when RAM_LINE_STATS_EN is defined.
// Ports:
//   clk            : rising-edge clock
//   rst            : synchronous active-high reset (storage is preserved)
//   ram_req        : request, held high until ram_ready
//   ram_address    : byte address; line index taken above the offset bits
//   ram_we         : 1 = write-back, 0 = fetch
//   ram_write_data : line to store on a write-back
//   ram_ready      : one-cycle completion pulse
//   ram_read_data  : fetched line, valid with ram_ready on a fetch; held otherwise
//   ram_busy       : high from acceptance through the ram_ready cycle
//   stat_reads/stat_writes/stat_aborts : (RAM_LINE_STATS_EN only) counters
module ram_line_model
  import ram_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int LATENCY  = 8,
  parameter int OFFSET_W = DEFAULT_OFFSET_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_req,
  input  logic [ADDR_W-1:0] ram_address,
  input  logic              ram_we,
  input  logic [LINE_W-1:0] ram_write_data,
  output logic              ram_ready,
  output logic [LINE_W-1:0] ram_read_data,
  output logic              ram_busy
`ifdef RAM_LINE_STATS_EN
  ,
  output logic [31:0]       stat_reads,
  output logic [31:0]       stat_writes,
  output logic [15:0]       stat_aborts
`endif
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  lat_idx;
  logic              lat_we;
  logic [LINE_W-1:0] lat_data;

  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  arr_idx;
  logic              eff_we;
  logic              rd_en;
  logic              wr_en;
  logic              addr_unused;

  assign req_idx     = ram_address[OFFSET_W +: IDX_W];
  assign addr_unused = ^{ram_address[ADDR_W-1:OFFSET_W+IDX_W],
                         ram_address[OFFSET_W-1:0]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. The counter is loaded with LATENCY-1 and the move to
  // RESPOND happens on the decrement that brings it to zero, so the ready
  // cycle lands LATENCY cycles after acceptance for every LATENCY >= 1.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (ram_req) begin
          next_state = (LATENCY == 1) ? RESPOND : BUSY;
        end
      end
      BUSY: begin
        if (!ram_req) begin
          next_state = IDLE;
        end else if (cnt == CNT_W'(1)) begin
          next_state = RESPOND;
        end
      end
      RESPOND: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ram_ready = (state == RESPOND);
    ram_busy  = (state != IDLE);
  end

  // Request latch and latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      lat_idx  <= '0;
      lat_we   <= 1'b0;
      lat_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ram_req) begin
            cnt      <= CNT_W'(LATENCY - 1);
            lat_idx  <= req_idx;
            lat_we   <= ram_we;
            lat_data <= ram_write_data;
          end
        end
        BUSY: begin
          if (!ram_req) begin
            cnt <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The array is read on the edge entering RESPOND (so data is valid with
  // ram_ready) and written on the edge leaving it. In IDLE the live request
  // fields are used so that LATENCY=1 can read on its acceptance edge.
  always_comb begin
    arr_idx = (state == IDLE) ? req_idx : lat_idx;
    eff_we  = (state == IDLE) ? ram_we  : lat_we;
    rd_en   = (next_state == RESPOND) && !eff_we;
    wr_en   = (state == RESPOND) && lat_we;
  end

  ram_line_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .en         (rd_en || wr_en),
    .we         (wr_en),
    .index      (wr_en ? lat_idx : arr_idx),
    .write_data (lat_data),
    .read_data  (ram_read_data)
  );

`ifdef RAM_LINE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_aborts <= '0;
    end else begin
      if (state == RESPOND) begin
        if (lat_we) begin
          stat_writes <= stat_writes + 32'd1;
        end else begin
          stat_reads <= stat_reads + 32'd1;
        end
      end
      if (state == BUSY && !ram_req) begin
        stat_aborts <= stat_aborts + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_line_model.sv
// tb_ram_line_model: directed plus randomized bench for ram_line_model.
// A behavioural model (associative array of lines keyed by line index,
// expected read-data register and transaction counters) predicts results.
module tb_ram_line_model;

  localparam int LAT   = 8;
  localparam int DEP   = 1024;
  localparam int OFFW  = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         ram_req;
  logic [31:0]  ram_address;
  logic         ram_we;
  logic [511:0] ram_write_data;
  logic         ram_ready;
  logic [511:0] ram_read_data;
  logic         ram_busy;
`ifdef RAM_LINE_STATS_EN
  logic [31:0]  stat_reads;
  logic [31:0]  stat_writes;
  logic [15:0]  stat_aborts;
`endif

  always #5 clk = ~clk;

  ram_line_model #(
    .DEPTH    (DEP),
    .LATENCY  (LAT),
    .OFFSET_W (OFFW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ram_req        (ram_req),
    .ram_address    (ram_address),
    .ram_we         (ram_we),
    .ram_write_data (ram_write_data),
    .ram_ready      (ram_ready),
    .ram_read_data  (ram_read_data),
    .ram_busy       (ram_busy)
`ifdef RAM_LINE_STATS_EN
    ,
    .stat_reads     (stat_reads),
    .stat_writes    (stat_writes),
    .stat_aborts    (stat_aborts)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_ready_cyc = -100;
  bit prev_keep = 1'b0;

  logic [511:0] model [int];
  logic [511:0] exp_rd;
  int exp_reads, exp_writes, exp_aborts;
  logic [31:0] pool [8];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 64) % DEP);
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk_stats();
`ifdef RAM_LINE_STATS_EN
    chk("stat_reads", stat_reads, exp_reads);
    chk("stat_writes", stat_writes, exp_writes);
    chk("stat_aborts", stat_aborts, exp_aborts & 16'hFFFF);
`endif
  endtask

  task automatic clear_model_regs();
    exp_rd = '0;
    exp_reads = 0;
    exp_writes = 0;
    exp_aborts = 0;
  endtask

  // Called at a negedge with the DUT idle; ends at a negedge, DUT idle.
  task automatic reset_pulse();
    rst = 1'b1;
    ram_req = 1'b0;
    @(negedge clk);
    clear_model_regs();
    chk("rst_ready", ram_ready, 1'b0);
    chk("rst_busy", ram_busy, 1'b0);
    chk("rst_rdata", ram_read_data, exp_rd);
    chk_stats();
    rst = 1'b0;
    prev_keep = 1'b0;
  endtask

  // One transaction. Acceptance edge T is the first posedge after entry.
  // abort_k: drop req so it is seen low at edge T+abort_k (1..LAT-1), 0 = none.
  // rst_k: reset seen at edge T+rst_k (1..LAT-1), 0 = none.
  // keep: leave req high after ready so the next call chains.
  task automatic txn(input logic [31:0] addr, input logic we, input logic [511:0] data,
                     input int abort_k, input int rst_k, input bit keep);
    bit completes;
    int idx;
    completes = (abort_k == 0) && (rst_k == 0);
    idx = idx_of(addr);
    ram_address = addr;
    ram_we = we;
    ram_write_data = data;
    ram_req = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      if (rst_k > 0 && k == rst_k) clear_model_regs();
      if (rst_k > 0 && k >= rst_k) begin
        chk("kill_busy", ram_busy, 1'b0);
        chk("kill_ready", ram_ready, 1'b0);
        chk("kill_rdata", ram_read_data, exp_rd);
      end else if (abort_k > 0 && k >= abort_k) begin
        chk("abort_busy", ram_busy, 1'b0);
        chk("abort_ready", ram_ready, 1'b0);
      end else begin
        chk("busy", ram_busy, k < LAT);
        chk("ready", ram_ready, k == LAT - 1);
      end
      if (completes && k == LAT - 1) begin
        if (prev_keep) chk("chain_spacing", cyc - last_ready_cyc, LAT + 1);
        last_ready_cyc = cyc;
        if (!we) begin
          exp_rd = model[idx];
          exp_reads++;
          chk("read_data", ram_read_data, exp_rd);
        end else begin
          exp_writes++;
          chk("write_rdata_hold", ram_read_data, exp_rd);
        end
      end
      if (completes && k == LAT && we) model[idx] = data;
      if (k == LAT) chk("rdata_hold", ram_read_data, exp_rd);
      // Stimulus for the next edge
      if (rst_k > 0 && k == rst_k) rst = 1'b0;
      if (abort_k > 0 && k == abort_k - 1) begin
        ram_req = 1'b0;
        exp_aborts++;
      end else if (rst_k > 0 && k == rst_k - 1) begin
        rst = 1'b1;
        ram_req = 1'b0;
      end else if (completes && k == LAT - 1) begin
        if (!keep) ram_req = 1'b0;
      end else if (k < LAT - 1 && ram_req) begin
        // Fields must be frozen once accepted
        ram_address = $urandom;
        ram_we = 1'($urandom);
        ram_write_data = rand_line();
      end
    end
    chk_stats();
    prev_keep = keep && completes;
  endtask

  logic [511:0] line_a, line_b, line_c;

  initial begin
    rst = 1'b1;
    ram_req = 1'b0;
    ram_address = '0;
    ram_we = 1'b0;
    ram_write_data = '0;
    clear_model_regs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", ram_ready, 1'b0);
    chk("reset_busy", ram_busy, 1'b0);
    chk("reset_rdata", ram_read_data, '0);
    chk_stats();
    rst = 1'b0;

    // Line 1 preloaded, survives a reset, then fetched
    line_a = rand_line();
    txn(32'h0000_0040, 1'b1, line_a, 0, 0, 1'b0);
    reset_pulse();
    txn(32'h0000_0040, 1'b0, '0, 0, 0, 1'b0);
    chk("preload_line1", ram_read_data, line_a);

    // Write then read
    txn(32'h0000_1000, 1'b1, {16{32'hDEADBEEF}}, 0, 0, 1'b0);
    txn(32'h0000_1000, 1'b0, '0, 0, 0, 1'b0);
    chk("deadbeef", ram_read_data, {16{32'hDEADBEEF}});

    // Write-back chain followed by refill
    txn(32'h0000_3000, 1'b1, rand_line(), 0, 0, 1'b0);
    txn(32'h0000_2000, 1'b1, rand_line(), 0, 0, 1'b1);
    txn(32'h0000_3000, 1'b0, '0, 0, 0, 1'b0);

    // Aborted read and aborted write
    txn(32'h0000_1000, 1'b0, '0, 3, 0, 1'b0);
    txn(32'h0000_1000, 1'b1, rand_line(), 3, 0, 1'b0);
    txn(32'h0000_1000, 1'b0, '0, 0, 0, 1'b0);
    chk("abort_no_write", ram_read_data, {16{32'hDEADBEEF}});

    // Aliasing modulo DEPTH lines
    line_b = rand_line();
    txn(32'h0001_0000, 1'b1, line_b, 0, 0, 1'b0);
    txn(32'h0000_0000, 1'b0, '0, 0, 0, 1'b0);
    chk("alias", ram_read_data, line_b);

    // Reset in the middle of a write
    line_c = rand_line();
    txn(32'h0000_5000, 1'b1, line_c, 0, 0, 1'b0);
    txn(32'h0000_5000, 1'b1, rand_line(), 0, 4, 1'b0);
    txn(32'h0000_5000, 1'b0, '0, 0, 0, 1'b0);
    chk("reset_no_write", ram_read_data, line_c);

    // Counter scenario: 3 reads, 2 writes, 1 abort after a reset
    reset_pulse();
    txn(32'h0000_0040, 1'b0, '0, 0, 0, 1'b0);
    txn(32'h0000_6000, 1'b1, rand_line(), 0, 0, 1'b0);
    txn(32'h0000_1000, 1'b0, '0, 0, 0, 1'b0);
    txn(32'h0000_7000, 1'b1, rand_line(), 0, 0, 1'b1);
    txn(32'h0000_6000, 1'b0, '0, 0, 0, 1'b0);
    txn(32'h0000_7000, 1'b0, '0, 2, 0, 1'b0);
`ifdef RAM_LINE_STATS_EN
    chk("stats_reads_3", stat_reads, 32'd3);
    chk("stats_writes_2", stat_writes, 32'd2);
    chk("stats_aborts_1", stat_aborts, 16'd1);
`endif

    // Randomized traffic over a small pool of preloaded lines
    for (int i = 0; i < 8; i++) begin
      pool[i] = {$urandom_range(0, 255), 24'h0} | (32'($urandom_range(0, DEP - 1)) << OFFW)
                | 32'($urandom_range(0, 63));
      txn(pool[i], 1'b1, rand_line(), 0, 0, 1'b0);
    end
    for (int i = 0; i < 48; i++) begin
      logic [31:0] a;
      int sel, ab, rk;
      sel = $urandom_range(0, 7);
      // Same line index, different offset/upper bits
      a = (pool[sel] & 32'h0000_FFC0) | ({$urandom_range(0, 255), 24'h0})
          | 32'($urandom_range(0, 63));
      ab = 0;
      rk = 0;
      if ($urandom_range(0, 7) == 0) ab = $urandom_range(1, LAT - 1);
      else if ($urandom_range(0, 15) == 0) rk = $urandom_range(1, LAT - 1);
      txn(a, 1'($urandom), rand_line(), ab, rk, ($urandom_range(0, 2) == 0));
    end
    ram_req = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
